// File: rtl/irq_pkg.sv
// Shared encodings for the two-source interrupt controller: per-source state
// codes, ack codes and the ack-to-retire decode.
package irq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_PEND  = 2'b01,
        S_SERV  = 2'b10,
        S_REARM = 2'b11
    } src_state_t;

    localparam logic [1:0] ACK_NONE = 2'b00;
    localparam logic [1:0] ACK_ONE  = 2'b01;
    localparam logic [1:0] ACK_ZERO = 2'b10;
    localparam logic [1:0] ACK_BOTH = 2'b11;

    // ACK_BOTH retires only source zero; source one stays in service.
    // Acks for bits not currently presented are dropped.
    function automatic logic [1:0] ack_clear(input logic [1:0] active,
                                             input logic [1:0] ack);
        logic [1:0] clr;
        clr = 2'b00;
        if (ack == ACK_ZERO || ack == ACK_BOTH) clr[1] = active[1];
        if (ack == ACK_ONE)                     clr[0] = active[0];
        return clr;
    endfunction

endpackage

// File: rtl/irq_src.sv
// One interrupt source: optional two-flop synchronizer (IRQ_CTRL_SYNC_EN),
// edge/level detector, per-source FSM and sticky overrun bit.
module irq_src
    import irq_pkg::*;
#(
    parameter logic EDGE = 1'b1
) (
    input  logic clk,
    input  logic s_reset_h,
    input  logic raw,
    input  logic en,
    input  logic grant,
    input  logic ack,
    input  logic ovr_clr,
    output logic req,
    output logic pending,
    output logic overrun
);

    logic       sig;
    logic       prev;
    logic       evt;
    src_state_t state;

`ifdef IRQ_CTRL_SYNC_EN
    logic sync1, sync2;

    always_ff @(posedge clk) begin
        if (s_reset_h) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    assign sig = sync2;
`else
    assign sig = raw;
`endif

    assign evt     = EDGE ? (sig & ~prev) : sig;
    // A fresh event from idle can be presented on the same edge it is detected.
    assign req     = en && ((state == S_PEND) || (state == S_IDLE && evt));
    assign pending = (state == S_PEND) || (state == S_SERV);

    always_ff @(posedge clk) begin
        if (s_reset_h) begin
            state   <= S_IDLE;
            prev    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            prev <= sig;
            if (EDGE && evt && (state == S_PEND || (state == S_SERV && !ack)))
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;

            case (state)
                S_IDLE:  if (req) state <= grant ? S_SERV : S_PEND;
                S_PEND: begin
                    if (!en)        state <= S_IDLE;
                    else if (grant) state <= S_SERV;
                end
                S_SERV: begin
                    // Ack is retired first, so an edge arriving with it is kept.
                    if (ack) begin
                        if (!EDGE)           state <= S_REARM;
                        else if (evt && en)  state <= S_PEND;
                        else                 state <= S_IDLE;
                    end
                end
                S_REARM: if (!sig) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Two-source interrupt controller top: presentation register with freeze
// until acked, ack decode, two irq_src instances. Sync option: IRQ_CTRL_SYNC_EN.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter logic [1:0] EDGE_MASK = 2'b11
) (
    input  logic       clk,
    input  logic       s_reset_h,
    input  logic [1:0] irq_raw,
    input  logic [1:0] irq_en,
    input  logic [1:0] irq_ack,
    input  logic       irq_ovr_clr,
    output logic [1:0] irq_active,
    output logic [1:0] irq_pending,
    output logic [1:0] irq_overrun
);

    logic [1:0] req;
    logic [1:0] ack_clr;
    logic       idle;

    assign idle    = (irq_active == 2'b00);
    assign ack_clr = ack_clear(irq_active, irq_ack);

    generate
        for (genvar i = 0; i < 2; i++) begin : g_src
            irq_src #(.EDGE(EDGE_MASK[i])) u_src (
                .clk       (clk),
                .s_reset_h (s_reset_h),
                .raw       (irq_raw[i]),
                .en        (irq_en[i]),
                .grant     (idle),
                .ack       (ack_clr[i]),
                .ovr_clr   (irq_ovr_clr),
                .req       (req[i]),
                .pending   (irq_pending[i]),
                .overrun   (irq_overrun[i])
            );
        end
    endgenerate

    // Load only when empty; otherwise the vector can only shrink via acks.
    always_ff @(posedge clk) begin
        if (s_reset_h)  irq_active <= 2'b00;
        else if (idle)  irq_active <= req;
        else            irq_active <= irq_active & ~ack_clr;
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: an edge-mode and a level-mode instance, checked every
// cycle against a behavioural model plus hand-computed literal expectations.
module tb_irq_ctrl;

`ifdef IRQ_CTRL_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] raw [2];
    logic [1:0] en  [2];
    logic [1:0] ack [2];
    logic       clr [2];
    logic [1:0] act [2];
    logic [1:0] pend[2];
    logic [1:0] ovr [2];

    int checks = 0;
    int errors = 0;
    bit started = 0;

    irq_ctrl #(.EDGE_MASK(2'b11)) dut_e (
        .clk(clk), .s_reset_h(rst), .irq_raw(raw[0]), .irq_en(en[0]),
        .irq_ack(ack[0]), .irq_ovr_clr(clr[0]),
        .irq_active(act[0]), .irq_pending(pend[0]), .irq_overrun(ovr[0]));

    irq_ctrl #(.EDGE_MASK(2'b00)) dut_l (
        .clk(clk), .s_reset_h(rst), .irq_raw(raw[1]), .irq_en(en[1]),
        .irq_ack(ack[1]), .irq_ovr_clr(clr[1]),
        .irq_active(act[1]), .irq_pending(pend[1]), .irq_overrun(ovr[1]));

    // Model: unit 0 is all-edge, unit 1 all-level; b indexes irq bits.
    logic [1:0] m_act[2], m_ovr[2], m_h0[2], m_h1[2];
    bit m_pend[2][2], m_serv[2][2], m_low[2][2], m_prev[2][2];

    function automatic logic [1:0] m_pvec(input int u);
        return {m_pend[u][1] | m_serv[u][1], m_pend[u][0] | m_serv[u][0]};
    endfunction

    task automatic model_step(input int u);
        logic [1:0] s, done;
        bit is_edge, ev;
        is_edge = (u == 0);
        if (rst) begin
            m_act[u] = 2'b00; m_ovr[u] = 2'b00; m_h0[u] = 2'b00; m_h1[u] = 2'b00;
            for (int b = 0; b < 2; b++) begin
                m_pend[u][b] = 0; m_serv[u][b] = 0; m_low[u][b] = 0; m_prev[u][b] = 0;
            end
            return;
        end
        if (LAT == 0) s = raw[u];
        else begin
            s = m_h1[u]; m_h1[u] = m_h0[u]; m_h0[u] = raw[u];
        end
        done = 2'b00;
        if (m_act[u][1] && ack[u][1])       done[1] = 1'b1;
        if (m_act[u][0] && ack[u] == 2'b01) done[0] = 1'b1;
        if (clr[u]) m_ovr[u] = 2'b00;
        for (int b = 0; b < 2; b++) begin
            ev = is_edge ? (s[b] && !m_prev[u][b]) : s[b];
            m_prev[u][b] = s[b];
            if (m_serv[u][b]) begin
                if (done[b]) begin
                    m_serv[u][b] = 0;
                    if (!is_edge) m_low[u][b] = 1;
                    else if (ev && en[u][b]) m_pend[u][b] = 1;
                end else if (is_edge && ev) m_ovr[u][b] = 1'b1;
            end else if (m_pend[u][b]) begin
                if (is_edge && ev) m_ovr[u][b] = 1'b1;
                if (!en[u][b]) m_pend[u][b] = 0;
            end else if (m_low[u][b]) begin
                if (!s[b]) m_low[u][b] = 0;
            end else if (ev && en[u][b]) m_pend[u][b] = 1;
        end
        if (m_act[u] == 2'b00) begin
            for (int b = 0; b < 2; b++)
                if (m_pend[u][b]) begin
                    m_act[u][b] = 1'b1; m_pend[u][b] = 0; m_serv[u][b] = 1;
                end
        end else m_act[u] = m_act[u] & ~done;
    endtask

    always @(posedge clk) begin
        started = 1;
        for (int u = 0; u < 2; u++) model_step(u);
    end

    task automatic chk(input string nm, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            for (int u = 0; u < 2; u++) begin
                chk($sformatf("model_active%0d", u),  act[u],  m_act[u]);
                chk($sformatf("model_pending%0d", u), pend[u], m_pvec(u));
                chk($sformatf("model_overrun%0d", u), ovr[u],  m_ovr[u]);
            end
        end
    end

    task automatic cyc(input int u, input logic [1:0] r, input logic [1:0] a, input logic c);
        raw[u] = r; ack[u] = a; clr[u] = c;
        @(posedge clk); #1;
    endtask

    task automatic hold(input int u, input logic [1:0] r, input int n);
        for (int i = 0; i < n; i++) cyc(u, r, 2'b00, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            raw[u] = 2'b00; en[u] = 2'b11; ack[u] = 2'b00; clr[u] = 1'b0;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_active", act[0], 2'b00);
        chk("reset_pending", pend[0], 2'b00);
        chk("reset_overrun", ovr[0], 2'b00);
        rst = 1'b0;
        hold(0, 2'b00, 2);

        // edge source one, then ack
        cyc(0, 2'b01, 2'b00, 1'b0); hold(0, 2'b00, LAT);
        chk("t1_active", act[0], 2'b01);
        chk("t1_pending", pend[0], 2'b01);
        cyc(0, 2'b00, 2'b01, 1'b0);
        chk("t1_ack_active", act[0], 2'b00);
        chk("t1_ack_pending", pend[0], 2'b00);

        // both at once; ack 11 leaves source one
        cyc(0, 2'b11, 2'b00, 1'b0); hold(0, 2'b00, LAT);
        chk("t2_active", act[0], 2'b11);
        cyc(0, 2'b00, 2'b11, 1'b0);
        chk("t2_ack11", act[0], 2'b01);
        cyc(0, 2'b00, 2'b01, 1'b0);
        chk("t2_ack01", act[0], 2'b00);

        // freeze while source one in service
        cyc(0, 2'b01, 2'b00, 1'b0); hold(0, 2'b00, LAT);
        cyc(0, 2'b10, 2'b00, 1'b0); hold(0, 2'b00, LAT);
        chk("t3_frozen", act[0], 2'b01);
        chk("t3_pending", pend[0], 2'b11);
        cyc(0, 2'b00, 2'b01, 1'b0);
        chk("t3_ack_active", act[0], 2'b00);
        hold(0, 2'b00, 1);
        chk("t3_next", act[0], 2'b10);
        cyc(0, 2'b00, 2'b10, 1'b0);

        // ack and new event on the same edge
        cyc(0, 2'b01, 2'b00, 1'b0); hold(0, 2'b00, LAT);
        for (int i = 0; i <= LAT; i++)
            cyc(0, (i == 0) ? 2'b10 : 2'b00, (i == LAT) ? 2'b01 : 2'b00, 1'b0);
        chk("t4_ack_first", act[0], 2'b00);
        chk("t4_pending", pend[0], 2'b10);
        hold(0, 2'b00, 1);
        chk("t4_next", act[0], 2'b10);
        cyc(0, 2'b00, 2'b10, 1'b0);

        // overrun, clear vs set, clear, masked source
        cyc(0, 2'b01, 2'b00, 1'b0); hold(0, 2'b00, LAT + 1);
        cyc(0, 2'b01, 2'b00, 1'b0); hold(0, 2'b00, LAT);
        chk("t5_overrun", ovr[0], 2'b01);
        chk("t5_active", act[0], 2'b01);
        hold(0, 2'b00, 1);
        for (int i = 0; i <= LAT; i++)
            cyc(0, (i == 0) ? 2'b01 : 2'b00, 2'b00, i == LAT);
        chk("t5_set_wins", ovr[0], 2'b01);
        cyc(0, 2'b00, 2'b00, 1'b1);
        chk("t5_cleared", ovr[0], 2'b00);
        cyc(0, 2'b00, 2'b01, 1'b0);
        chk("t5_ack", act[0], 2'b00);
        en[0] = 2'b10;
        cyc(0, 2'b01, 2'b00, 1'b0); hold(0, 2'b00, LAT + 1);
        chk("t5_masked_pending", pend[0], 2'b00);
        chk("t5_masked_active", act[0], 2'b00);
        en[0] = 2'b11;

        // level re-arm on the level-mode instance
        hold(1, 2'b10, LAT + 1);
        chk("t6_active", act[1], 2'b10);
        cyc(1, 2'b10, 2'b10, 1'b0);
        chk("t6_ack", act[1], 2'b00);
        hold(1, 2'b10, 3);
        chk("t6_held_active", act[1], 2'b00);
        chk("t6_held_pending", pend[1], 2'b00);
        hold(1, 2'b00, LAT + 1);
        hold(1, 2'b10, LAT + 1);
        chk("t6_rearmed", act[1], 2'b10);
        chk("t6_no_overrun", ovr[1], 2'b00);
        cyc(1, 2'b00, 2'b10, 1'b0);
        hold(1, 2'b00, LAT + 2);
        chk("t6_done", act[1], 2'b00);

        // reset mid-service
        cyc(0, 2'b11, 2'b00, 1'b0); hold(0, 2'b00, LAT);
        chk("t7_active", act[0], 2'b11);
        rst = 1'b1;
        cyc(0, 2'b00, 2'b00, 1'b0);
        chk("t7_rst_active", act[0], 2'b00);
        chk("t7_rst_pending", pend[0], 2'b00);
        chk("t7_rst_overrun", ovr[0], 2'b00);
        rst = 1'b0;
        cyc(0, 2'b00, 2'b10, 1'b0);
        chk("t7_stray_ack", act[0], 2'b00);
        hold(0, 2'b00, 2);
        chk("t7_quiet", pend[0], 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Two-source interrupt controller presenting `irq_active[1:0]` to the multicycle control FSM and consuming its `irq_ack[1:0]` pulses. Synchronizes and detects raw requests, records pending requests, freezes the presented vector until acknowledged, and re-arms each source. Sits between the SoC peripheral interrupt lines and the core control FSM.

## Interface
- `EDGE_MASK`, 2'b11: per-source detect mode, bit=1 rising-edge, bit=0 level-high; bit1 = source zero, bit0 = source one.
- `clk`  in  1  system clock, all logic on rising edge.
- `s_reset_h`  in  1  reset; synchronous, active-high (fixed).
- `irq_raw`  in  2  raw requests; [1] = source zero (high priority), [0] = source one.
- `irq_en`  in  2  per-source enable; masked sources never become pending.
- `irq_ack`  in  2  from control FSM; 2'b10 ack zero, 2'b01 ack one, 2'b11 ack zero with one still pending, 2'b00 idle.
- `irq_ovr_clr`  in  1  clears `irq_overrun`.
- `irq_active`  out  2  presented request vector, registered.
- `irq_pending`  out  2  raw pending status per source (not frozen).
- `irq_overrun`  out  2  sticky: request lost while source already pending/in service.

## Operation
- Per-source FSM, states S_IDLE, S_PEND, S_SERV, S_REARM:
  - S_IDLE: detect event (edge: sync 0->1; level: sync==1) and `irq_en` bit set -> S_PEND.
  - S_PEND: selected into presentation at next freeze point -> S_SERV.
  - S_SERV: matching ack -> edge source S_IDLE; level source S_REARM.
  - S_REARM: sync==0 -> S_IDLE.
- Overrun: edge event in S_PEND/S_SERV sets the source's `irq_overrun` bit; level sources never overrun.
- `irq_en` bit dropping in S_PEND returns source to S_IDLE; in S_SERV has no effect (ack still required).
- Presentation: when `irq_active`==0, load it with the vector of sources in S_PEND (both -> 2'b11) and move those sources to S_SERV. While nonzero, `irq_active` is frozen; new arrivals only go to S_PEND.
- Ack decode: 2'b10 clears bit1 -> 2'b00; 2'b01 clears bit0 -> 2'b00; 2'b11 clears bit1 only -> `irq_active` becomes 2'b01, source one stays S_SERV. Ack for a bit not set in `irq_active` is ignored, no state change.
- `irq_pending[i]` = source i in S_PEND or S_SERV.

## Timing
- Reset: all sources S_IDLE, sync/edge flops 0, `irq_active`=00, `irq_pending`=00, `irq_overrun`=00.
- Raw-to-`irq_active`: 3 cycles with sync (2 sync + 1 present), 1 cycle without.
- Ack sampled on edge N updates `irq_active` on the same edge N; the FSM's following FETCH sees the cleared/reduced vector. Newly pending source presented earliest at edge N+1.
- Ack and new event same cycle: ack applied first, event goes to S_PEND, presented next cycle.
- `irq_ovr_clr` and new overrun same cycle: set wins.
- Reset mid-service drops all pending/in-service state; no ack required afterwards.

## Configuration
- `IRQ_CTRL_SYNC_EN` defined: two-flop synchronizer per `irq_raw` bit ahead of detection.
- Undefined: `irq_raw` used directly (same clock domain sources only); latencies shrink by 2 cycles, all other behaviour identical.

## Structure
- Package `irq_pkg`: per-source state encodings (S_IDLE=2'b00, S_PEND=2'b01, S_SERV=2'b10, S_REARM=2'b11), ack codes ACK_ZERO=2'b10, ACK_ONE=2'b01, ACK_BOTH=2'b11.
- Sub-module `irq_src`: synchronizer, detector, per-source FSM, overrun bit; instantiated twice. Top holds presentation register and ack decode.

## Test plan
- Edge source one: `irq_raw`=01 pulse, `irq_en`=11 -> `irq_active`=01 after 3 cycles; `irq_ack`=01 -> `irq_active`=00 same edge, `irq_pending`=00.
- Both simultaneous: `irq_raw`=11 -> `irq_active`=11; ack 11 -> 01; ack 01 -> 00.
- Freeze: source one presented (01), source zero fires -> `irq_active` stays 01, `irq_pending`=11; ack 01 -> next cycle `irq_active`=10.
- Level re-arm (`EDGE_MASK`=00): hold `irq_raw`[1]=1 through ack 10 -> no re-presentation until raw drops then rises; `irq_active` returns to 10 only then.
- Overrun: source one edge twice before ack -> `irq_overrun`=01; `irq_ovr_clr` -> 00; masked source (`irq_en`=10) edge on bit0 -> no pending.
- Reset with `irq_active`=11 asserted -> all outputs 00 next cycle; stray ack 10 afterwards ignored.
